// File: rtl/alu_panel_pkg.sv
// -----------------------------------------------------------------------------
// alu_panel_pkg
// Shared types for the ALU entry front panel: the 4-bit ALU operation code,
// bit positions of the {C,V,N,Z} flag vector and the execution FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_panel_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_INC   = 4'd2,
    OP_DEC   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_NOTA  = 4'd6,
    OP_NOTB  = 4'd7,
    OP_NAND  = 4'd8,
    OP_XOR   = 4'd9,
    OP_XNOR  = 4'd10,
    OP_SLL   = 4'd11,
    OP_SRL   = 4'd12,
    OP_SLT   = 4'd13,
    OP_SGE   = 4'd14,
    OP_PASSB = 4'd15
  } alu_op_e;

  // Bit positions inside flag_o = {C,V,N,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/alu_entry_panel_debounce.sv
// -----------------------------------------------------------------------------
// panel_debounce
// Debouncer for one active-low raw push-button. The raw level is brought in
// through a 2-FF synchroniser; a counter runs while the synchronised level
// differs from the accepted (stable) level and the stable level flips once it
// has differed for DEB_CYCLES consecutive cycles. A one-cycle pulse is emitted
// when the stable level becomes "pressed" (low); releases are silent.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous reset, active-high (button treated as released)
//   btn_n_i  raw button level, low = pressed
//   pulse_o  one-cycle press pulse
// -----------------------------------------------------------------------------
module panel_debounce #(
  parameter int DEB_CYCLES = 20_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic pulse_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  logic w_differ;
  logic w_flip;

  assign w_differ = (r_sync2 != r_stable);
  assign w_flip   = w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_pulse  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= btn_n_i;
      r_sync2 <= r_sync1;
      // Pulse only on the flip towards the pressed (low) level
      r_pulse <= w_flip & ~r_sync2;
      if (w_flip) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign pulse_o = r_pulse;

endmodule

// File: rtl/alu_entry_panel.sv
// -----------------------------------------------------------------------------
// alu_entry_panel
// Front-panel controller: four debounced buttons and a 4-bit switch bank load
// nibbles into a NUM_REGS x WIDTH register file; the exec button runs a
// registered ALU op between two selected registers and writes the result back
// to the register under the register cursor (IDLE -> EXEC -> WRITE -> IDLE).
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   btn_*_i               raw active-low buttons (enter, next nibble,
//                         next register, execute)
//   sw_nibble_i           nibble written by enter
//   alu_op_i              operation code (alu_op_e)
//   src_a_i, src_b_i      ALU source registers
//   display_o             contents of reg[reg_cursor] (combinational)
//   nib_cursor_o          selected nibble
//   reg_cursor_o          selected register / write-back destination
//   flag_o                {C,V,N,Z} of the last executed op
//   busy_o                execution in progress
//   digit_blank_o         per-digit blank mask
// Optional feature: define ALU_ENTRY_PANEL_BLINK_EN to blink the digit under
// the nibble cursor from a free-running 2^23-cycle counter while idle.
// -----------------------------------------------------------------------------
module alu_entry_panel
  import alu_panel_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int NUM_REGS   = 4,
  parameter int DEB_CYCLES = 20_000_000,
  localparam int NIBBLES   = WIDTH / 4,
  localparam int REG_W     = $clog2(NUM_REGS),
  localparam int NIB_W     = ($clog2(NIBBLES) > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               btn_enter_i,
  input  logic               btn_next_nib_i,
  input  logic               btn_next_reg_i,
  input  logic               btn_exec_i,
  input  logic [3:0]         sw_nibble_i,
  input  logic [3:0]         alu_op_i,
  input  logic [REG_W-1:0]   src_a_i,
  input  logic [REG_W-1:0]   src_b_i,
  output logic [WIDTH-1:0]   display_o,
  output logic [NIB_W-1:0]   nib_cursor_o,
  output logic [REG_W-1:0]   reg_cursor_o,
  output logic [3:0]         flag_o,
  output logic               busy_o,
  output logic [NIBBLES-1:0] digit_blank_o
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);
  localparam logic [NIB_W-1:0] NIB_LAST  = NIB_W'(NIBBLES - 1);
  localparam logic [REG_W-1:0] REG_LAST  = REG_W'(NUM_REGS - 1);

  // ---------------- button debouncing ----------------
  // Index order: 0 enter, 1 next nibble, 2 next register, 3 execute
  logic [3:0] w_btn_raw;
  logic [3:0] w_pulse;

  assign w_btn_raw = {btn_exec_i, btn_next_reg_i, btn_next_nib_i, btn_enter_i};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_deb
      panel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_n_i (w_btn_raw[gi]),
        .pulse_o (w_pulse[gi])
      );
    end
  endgenerate

  // ---------------- state ----------------
  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic [NIB_W-1:0] r_nib_cursor;
  logic [REG_W-1:0] r_reg_cursor;
  fsm_state_e       r_state;
  alu_op_e          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_result;
  logic             r_ovf;
  logic [3:0]       r_flag;

  logic [NIB_W-1:0] w_nib_inc;
  logic [REG_W-1:0] w_reg_inc;

  assign w_nib_inc = (r_nib_cursor == NIB_LAST) ? '0 : r_nib_cursor + NIB_W'(1);
  assign w_reg_inc = (r_reg_cursor == REG_LAST) ? '0 : r_reg_cursor + REG_W'(1);

  // ---------------- ALU (combinational, evaluated in EXEC) ----------------
  logic [WIDTH-1:0] w_operand2;   // B, or 1 for inc/dec
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;       // bit WIDTH is the borrow
  logic             w_a_lt_b;
  logic             w_shift_oor;
  logic [WIDTH:0]   w_alu;
  logic             w_ovf;

  assign w_operand2  = (r_op == OP_INC || r_op == OP_DEC) ? ONE : r_b;
  assign w_sum       = {1'b0, r_a} + {1'b0, w_operand2};
  assign w_diff      = {1'b0, r_a} - {1'b0, w_operand2};
  assign w_a_lt_b    = (r_a < r_b);
  assign w_shift_oor = (r_b >= SHIFT_LIM);

  always_comb begin
    w_alu = '0;
    w_ovf = 1'b0;
    case (r_op)
      OP_ADD, OP_INC: begin
        w_alu = w_sum;
        w_ovf = (r_a[MSB] == w_operand2[MSB]) && (w_sum[MSB] != r_a[MSB]);
      end
      OP_SUB, OP_DEC: begin
        w_alu = w_diff;
        w_ovf = (r_a[MSB] != w_operand2[MSB]) && (w_diff[MSB] != r_a[MSB]);
      end
      OP_AND:   w_alu = {1'b0, r_a & r_b};
      OP_OR:    w_alu = {1'b0, r_a | r_b};
      OP_NOTA:  w_alu = {1'b0, ~r_a};
      OP_NOTB:  w_alu = {1'b0, ~r_b};
      OP_NAND:  w_alu = {1'b0, ~(r_a & r_b)};
      OP_XOR:   w_alu = {1'b0, r_a ^ r_b};
      OP_XNOR:  w_alu = {1'b0, ~(r_a ^ r_b)};
      OP_SLL:   w_alu = w_shift_oor ? '0 : {1'b0, r_a << r_b};
      OP_SRL:   w_alu = w_shift_oor ? '0 : {1'b0, r_a >> r_b};
      OP_SLT:   w_alu = {{WIDTH{1'b0}}, w_a_lt_b};
      OP_SGE:   w_alu = {{WIDTH{1'b0}}, ~w_a_lt_b};
      OP_PASSB: w_alu = {1'b0, r_b};
      default:  w_alu = '0;
    endcase
  end

  // ---------------- control / register file ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_nib_cursor <= '0;
      r_reg_cursor <= '0;
      r_state      <= ST_IDLE;
      r_op         <= OP_ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_ovf        <= 1'b0;
      r_flag       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pulse[3]) begin
            // Exec has priority: other pulses this cycle are dropped
            r_a     <= r_regs[src_a_i];
            r_b     <= r_regs[src_b_i];
            r_op    <= alu_op_e'(alu_op_i);
            r_state <= ST_EXEC;
          end else begin
            // Enter uses the cursors as they were before this edge
            if (w_pulse[0]) r_regs[r_reg_cursor][4*r_nib_cursor +: 4] <= sw_nibble_i;
            if (w_pulse[2]) begin
              r_reg_cursor <= w_reg_inc;
              r_nib_cursor <= '0;
            end else if (w_pulse[1]) begin
              r_nib_cursor <= w_nib_inc;
            end
          end
        end
        ST_EXEC: begin
          r_result <= w_alu;
          r_ovf    <= w_ovf;
          r_state  <= ST_WRITE;
        end
        ST_WRITE: begin
          r_regs[r_reg_cursor] <= r_result[WIDTH-1:0];
          r_flag[FLAG_Z]       <= (r_result[WIDTH-1:0] == '0);
          r_flag[FLAG_N]       <= r_result[MSB];
          r_flag[FLAG_V]       <= r_ovf;
          // Non-arithmetic ops leave bit WIDTH at 0, so C is 0 for them
          r_flag[FLAG_C]       <= r_result[WIDTH];
          r_state              <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign display_o    = r_regs[r_reg_cursor];
  assign nib_cursor_o = r_nib_cursor;
  assign reg_cursor_o = r_reg_cursor;
  assign flag_o       = r_flag;
  assign busy_o       = (r_state != ST_IDLE);

  // ---------------- digit blanking ----------------
`ifdef ALU_ENTRY_PANEL_BLINK_EN
  logic [22:0] r_blink_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_blink_cnt <= '0;
    else       r_blink_cnt <= r_blink_cnt + 23'd1;
  end

  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_blink
      assign digit_blank_o[gi] = (r_state == ST_IDLE) &&
                                 (r_nib_cursor == NIB_W'(gi)) &&
                                 r_blink_cnt[22];
    end
  endgenerate
`else
  assign digit_blank_o = '0;
`endif

endmodule

// File: tb/tb_alu_entry_panel.sv
// -----------------------------------------------------------------------------
// tb_alu_entry_panel
// Self-checking bench for alu_entry_panel (WIDTH=24, NUM_REGS=4, DEB_CYCLES=4).
// A behavioural model (register array, cursors, flags computed with plain
// integer arithmetic) is updated after each button action; a compare process
// checks every output against it on each falling edge while the panel is
// quiescent. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_entry_panel;

  localparam int WIDTH = 24;
  localparam int NREGS = 4;
  localparam int NIBS  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn = 4'hF;      // 0 enter, 1 next nib, 2 next reg, 3 exec
  logic [3:0]  sw  = 4'h0;
  logic [3:0]  op  = 4'h0;
  logic [1:0]  src_a = 2'd0;
  logic [1:0]  src_b = 2'd0;

  logic [23:0] display_o;
  logic [2:0]  nib_cursor_o;
  logic [1:0]  reg_cursor_o;
  logic [3:0]  flag_o;
  logic        busy_o;
  logic [5:0]  digit_blank_o;

  always #5 clk = ~clk;

  alu_entry_panel #(.WIDTH(WIDTH), .NUM_REGS(NREGS), .DEB_CYCLES(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .btn_enter_i    (btn[0]),
    .btn_next_nib_i (btn[1]),
    .btn_next_reg_i (btn[2]),
    .btn_exec_i     (btn[3]),
    .sw_nibble_i    (sw),
    .alu_op_i       (op),
    .src_a_i        (src_a),
    .src_b_i        (src_b),
    .display_o      (display_o),
    .nib_cursor_o   (nib_cursor_o),
    .reg_cursor_o   (reg_cursor_o),
    .flag_o         (flag_o),
    .busy_o         (busy_o),
    .digit_blank_o  (digit_blank_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model
  logic [23:0] m_regs [NREGS];
  int          m_nib;
  int          m_rc;
  logic [3:0]  m_flag;
  bit          m_valid = 1'b0;
  int          busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge while the model is current
  always @(negedge clk) begin
    if (busy_o === 1'b1) busy_cnt++;
    if (m_valid && !rst) begin
      check("display",    32'(display_o),     32'(m_regs[m_rc]));
      check("nib_cursor", 32'(nib_cursor_o),  m_nib);
      check("reg_cursor", 32'(reg_cursor_o),  m_rc);
      check("flags",      32'(flag_o),        32'(m_flag));
      check("busy_idle",  32'(busy_o),        32'd0);
      check("blank",      32'(digit_blank_o), 32'd0);
    end
  end

  function automatic longint sx(input longint x);
    return (x >= 8388608) ? x - 16777216 : x;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 24'd0;
    m_nib  = 0;
    m_rc   = 0;
    m_flag = 4'd0;
  endtask

  task automatic m_enter(input logic [3:0] v);
    logic [23:0] sel;
    sel = 24'hF << (4 * m_nib);
    m_regs[m_rc] = (m_regs[m_rc] & ~sel) | (24'(v) << (4 * m_nib));
  endtask

  task automatic m_next_nib();
    m_nib = (m_nib + 1) % NIBS;
  endtask

  task automatic m_next_reg();
    m_rc  = (m_rc + 1) % NREGS;
    m_nib = 0;
  endtask

  task automatic m_exec(input int code, input int sa, input int sb);
    longint a, b, r, sr;
    bit c, v;
    logic [23:0] res;
    a = longint'(m_regs[sa]);
    b = longint'(m_regs[sb]);
    c = 1'b0; v = 1'b0; sr = 0; r = 0;
    case (code)
      0:  begin r = a + b; c = (r > 16777215); sr = sx(a) + sx(b); end
      1:  begin r = a - b; c = (a < b);        sr = sx(a) - sx(b); end
      2:  begin r = a + 1; c = (r > 16777215); sr = sx(a) + 1;     end
      3:  begin r = a - 1; c = (a < 1);        sr = sx(a) - 1;     end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = ~a;
      7:  r = ~b;
      8:  r = ~(a & b);
      9:  r = a ^ b;
      10: r = ~(a ^ b);
      11: r = (b >= 24) ? 0 : (a << b);
      12: r = (b >= 24) ? 0 : (a >> b);
      13: r = (a < b) ? 1 : 0;
      14: r = (a >= b) ? 1 : 0;
      default: r = b;
    endcase
    if (code <= 3) v = (sr > 8388607) || (sr < -8388608);
    res = 24'(r);
    m_regs[m_rc] = res;
    m_flag = {c, v, res[23], (res == 24'd0)};
  endtask

  // Hold the "early" buttons low for 'hold' cycles from the start and the
  // "late" buttons for 'hold' cycles starting 'delay' cycles later, then let
  // everything release and settle.
  task automatic press(input logic [3:0] early, input logic [3:0] late,
                       input int delay, input int hold);
    m_valid = 1'b0;
    for (int c = 0; c < hold + delay; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++)
        btn[k] = !((early[k] && c < hold) || (late[k] && c >= delay && c < delay + hold));
    end
    @(posedge clk); #1;
    btn = 4'hF;
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic commit();
    m_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_exec(input int code, input int sa, input int sb);
    op = 4'(code); src_a = 2'(sa); src_b = 2'(sb);
    busy_cnt = 0;
    press(4'b1000, 4'b0000, 0, 8);
    m_exec(code, sa, sb);
    commit();
    check("busy_cycles", busy_cnt, 32'd2);
  endtask

  initial begin
    bit found;
    int kind;
    m_reset();

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_display", 32'(display_o), 32'd0);
    check("rst_flags",   32'(flag_o),    32'd0);
    check("rst_busy",    32'(busy_o),    32'd0);
    check("rst_cursors", 32'({nib_cursor_o, reg_cursor_o}), 32'd0);
    commit();

    // ---- debounce: short glitch ignored, long press writes once ----
    sw = 4'h5;
    press(4'b0001, 4'b0000, 0, 3);
    commit();
    check("glitch_no_write", 32'(display_o), 32'h0);
    press(4'b0001, 4'b0000, 0, 8);
    m_enter(4'h5);
    commit();
    check("enter_once", 32'(display_o), 32'h000005);

    // ---- fill reg0 with F ----
    sw = 4'hF;
    for (int i = 0; i < NIBS; i++) begin
      press(4'b0001, 4'b0000, 0, 8); m_enter(4'hF); commit();
      press(4'b0010, 4'b0000, 0, 8); m_next_nib();  commit();
    end
    check("fill_ffffff", 32'(display_o),    32'hFFFFFF);
    check("nib_wrapped", 32'(nib_cursor_o), 32'd0);

    // ---- reg1 = 1, add reg0+reg1 into reg2 ----
    press(4'b0100, 4'b0000, 0, 8); m_next_reg(); commit();
    sw = 4'h1;
    press(4'b0001, 4'b0000, 0, 8); m_enter(4'h1); commit();
    press(4'b0100, 4'b0000, 0, 8); m_next_reg(); commit();
    do_exec(0, 0, 1);
    check("add_wrap_result", 32'(display_o), 32'h000000);
    check("add_wrap_flags",  32'(flag_o),    32'b1001);

    // ---- reg0 = 7FFFFF, add -> signed overflow ----
    press(4'b0100, 4'b0000, 0, 8); m_next_reg(); commit();
    press(4'b0100, 4'b0000, 0, 8); m_next_reg(); commit();
    for (int i = 0; i < 5; i++) begin
      press(4'b0010, 4'b0000, 0, 8); m_next_nib(); commit();
    end
    sw = 4'h7;
    press(4'b0001, 4'b0000, 0, 8); m_enter(4'h7); commit();
    check("reg0_7fffff", 32'(display_o), 32'h7FFFFF);
    do_exec(0, 0, 1);
    check("add_ovf_result", 32'(display_o), 32'h800000);
    check("add_ovf_flags",  32'(flag_o),    32'b0110);

    // ---- reg0 = 0 (pass reg2), then 0 - 1 ----
    do_exec(15, 0, 2);
    do_exec(1, 0, 1);
    check("sub_borrow_result", 32'(display_o), 32'hFFFFFF);
    check("sub_borrow_flags",  32'(flag_o),    32'b1010);

    // ---- reg1 = 24, sll by 24 -> 0 ----
    press(4'b0100, 4'b0000, 0, 8); m_next_reg(); commit();
    sw = 4'h8;
    press(4'b0001, 4'b0000, 0, 8); m_enter(4'h8); commit();
    press(4'b0010, 4'b0000, 0, 8); m_next_nib(); commit();
    sw = 4'h1;
    press(4'b0001, 4'b0000, 0, 8); m_enter(4'h1); commit();
    check("reg1_24", 32'(display_o), 32'h000018);
    do_exec(11, 0, 1);
    check("sll_oor_result", 32'(display_o), 32'h0);
    check("sll_oor_flags",  32'(flag_o),    32'b0001);

    // ---- exec + enter + next-nib in the same cycle: only exec acts ----
    sw = 4'h3; op = 4'd15; src_a = 2'd0; src_b = 2'd0;
    press(4'b1011, 4'b0000, 0, 8);
    m_exec(15, 0, 0);
    commit();
    check("simul_result", 32'(display_o),    32'hFFFFFF);
    check("simul_nib",    32'(nib_cursor_o), 32'd1);

    // ---- enter/next-reg pulses during EXEC and WRITE are ignored ----
    op = 4'd2; src_a = 2'd2; src_b = 2'd0;
    busy_cnt = 0;
    press(4'b1000, 4'b0101, 1, 8);
    m_exec(2, 2, 0);
    commit();
    check("busy1_reg_cursor", 32'(reg_cursor_o), 32'd1);
    check("busy1_result",     32'(display_o),    32'h000001);
    op = 4'd3; src_a = 2'd1;
    press(4'b1000, 4'b0110, 2, 8);
    m_exec(3, 1, 0);
    commit();
    check("busy2_reg_cursor", 32'(reg_cursor_o), 32'd1);
    check("busy2_flags",      32'(flag_o),       32'b0001);

    // ---- randomized actions ----
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: begin
          sw = 4'($urandom_range(0, 15));
          press(4'b0001, 4'b0000, 0, 8); m_enter(sw); commit();
        end
        1: begin press(4'b0010, 4'b0000, 0, 8); m_next_nib(); commit(); end
        2: begin press(4'b0100, 4'b0000, 0, 8); m_next_reg(); commit(); end
        default: do_exec(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)));
      endcase
    end

    // ---- reset during EXEC aborts without write-back ----
    m_valid = 1'b0;
    op = 4'd14; src_a = 2'd0; src_b = 2'd0;   // a >= a -> 1 if it were written
    @(posedge clk); #1 btn[3] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (busy_o) found = 1'b1;
    end
    check("rst_exec_reached", 32'(found), 32'd1);
    rst = 1'b1;
    btn = 4'hF;
    #2;
    check("rst_busy_async", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("rst_busy_next", 32'(busy_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    m_reset();
    repeat (20) @(posedge clk);
    #1;
    commit();
    check("rst_no_writeback", 32'(display_o),    32'd0);
    check("rst_reg_cursor",   32'(reg_cursor_o), 32'd0);
    check("rst_flags_after",  32'(flag_o),       32'd0);

    m_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
